pulse_env_player: RTL and testbench

Consumer end of the pulse interface driven by the pulse register. On each cstrobe it latches the pulse fields. It then walks the envelope memory starting at the address and for the length packed in env_word. Each envelope sample is presented together with the latched phase/freq/amp/cfg, cycle-aligned, to the downstream DDS/mixer stage. It sits between pulse_reg's pulse_iface output and the per-element signal generator.

---
 rtl/pulse_env_player.sv | 169 ++++++++++++++++
 tb/tb_pulse_env_player.sv | 276 +++++++++++++++++++++++++++
 2 files changed

// File: rtl/pulse_env_player.sv
// Pulse consumer: latches pulse fields on cstrobe, streams the envelope memory
// window and presents each sample with the parameters of the pulse that read it.
module pulse_env_player #(
  parameter int ENV_WIDTH      = 24,
  parameter int ENV_ADDR_WIDTH = 12,
  parameter int PHASE_WIDTH    = 17,
  parameter int FREQ_WIDTH     = 9,
  parameter int AMP_WIDTH      = 16,
  parameter int CFG_WIDTH      = 4,
  parameter int ENV_DATA_WIDTH = 32
) (
  input  logic                      clk,
  input  logic                      reset,
  input  logic                      cstrobe,
  input  logic [ENV_WIDTH-1:0]      env_word,
  input  logic [PHASE_WIDTH-1:0]    phase,
  input  logic [FREQ_WIDTH-1:0]     freq,
  input  logic [AMP_WIDTH-1:0]      amp,
  input  logic [CFG_WIDTH-1:0]      cfg,
  output logic                      env_rd_en,
  output logic [ENV_ADDR_WIDTH-1:0] env_addr,
  input  logic [ENV_DATA_WIDTH-1:0] env_data,
  output logic                      out_valid,
  output logic [ENV_DATA_WIDTH-1:0] out_env,
  output logic [PHASE_WIDTH-1:0]    out_phase,
  output logic [FREQ_WIDTH-1:0]     out_freq,
  output logic [AMP_WIDTH-1:0]      out_amp,
  output logic [CFG_WIDTH-1:0]      out_cfg,
  output logic                      busy,
  output logic                      pulse_done,
  output logic                      preempt
);

  localparam int LEN_W = ENV_WIDTH - ENV_ADDR_WIDTH;

  typedef enum logic {S_IDLE = 1'b0, S_PLAY = 1'b1} state_t;

  state_t                    state_q, state_d;
  logic [LEN_W-1:0]          cnt_q, cnt_d;
  logic                      done_q, done_d;
  logic                      preempt_q, preempt_d;

  logic [ENV_ADDR_WIDTH-1:0] start_q;
  logic [LEN_W-1:0]          len_q;
  logic [PHASE_WIDTH-1:0]    phase_q;
  logic [FREQ_WIDTH-1:0]     freq_q;
  logic [AMP_WIDTH-1:0]      amp_q;
  logic [CFG_WIDTH-1:0]      cfg_q;

  logic                      rd_q;
  logic [ENV_DATA_WIDTH-1:0] env_hold_q;
  logic [PHASE_WIDTH-1:0]    out_phase_q;
  logic [FREQ_WIDTH-1:0]     out_freq_q;
  logic [AMP_WIDTH-1:0]      out_amp_q;
  logic [CFG_WIDTH-1:0]      out_cfg_q;

  logic [LEN_W-1:0]          new_len;
  logic                      new_zero;
  logic                      last_rd;

  assign new_len  = env_word[ENV_WIDTH-1:ENV_ADDR_WIDTH];
  assign new_zero = (new_len == '0);
  assign last_rd  = (state_q == S_PLAY) && (cnt_q == len_q - LEN_W'(1));

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      state_q   <= S_IDLE;
      cnt_q     <= '0;
      done_q    <= 1'b0;
      preempt_q <= 1'b0;
    end else begin
      state_q   <= state_d;
      cnt_q     <= cnt_d;
      done_q    <= done_d;
      preempt_q <= preempt_d;
    end
  end

  // A cstrobe on the final read is a gapless hand-off, not an abort.
  always_comb begin
    state_d   = state_q;
    cnt_d     = cnt_q;
    done_d    = 1'b0;
    preempt_d = 1'b0;
    case (state_q)
      S_IDLE: begin
        if (cstrobe) begin
          done_d = new_zero;
          cnt_d  = '0;
          if (!new_zero) state_d = S_PLAY;
        end
      end
      S_PLAY: begin
        if (cstrobe) begin
          preempt_d = !last_rd;
          done_d    = last_rd | new_zero;
          cnt_d     = '0;
          state_d   = new_zero ? S_IDLE : S_PLAY;
        end else if (last_rd) begin
          done_d  = 1'b1;
          cnt_d   = '0;
          state_d = S_IDLE;
        end else begin
          cnt_d = cnt_q + LEN_W'(1);
        end
      end
      default: begin
        state_d = S_IDLE;
        cnt_d   = '0;
      end
    endcase
  end

  always_comb begin
    env_rd_en  = (state_q == S_PLAY);
    env_addr   = env_rd_en ? (start_q + ENV_ADDR_WIDTH'(cnt_q)) : '0;
    busy       = (state_q == S_PLAY);
    pulse_done = done_q;
    preempt    = preempt_q;
  end

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      start_q <= '0;
      len_q   <= '0;
      phase_q <= '0;
      freq_q  <= '0;
      amp_q   <= '0;
      cfg_q   <= '0;
    end else if (cstrobe) begin
      start_q <= env_word[ENV_ADDR_WIDTH-1:0];
      len_q   <= new_len;
      phase_q <= phase;
      freq_q  <= freq;
      amp_q   <= amp;
      cfg_q   <= cfg;
    end
  end

  // out_valid has no backpressure: a sample is consumed in the cycle it is valid.
  // Fields travel with the read so they match the data arriving one cycle later.
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      rd_q        <= 1'b0;
      env_hold_q  <= '0;
      out_phase_q <= '0;
      out_freq_q  <= '0;
      out_amp_q   <= '0;
      out_cfg_q   <= '0;
    end else begin
      rd_q <= env_rd_en;
      if (rd_q) env_hold_q <= env_data;
      if (env_rd_en) begin
        out_phase_q <= phase_q;
        out_freq_q  <= freq_q;
        out_amp_q   <= amp_q;
        out_cfg_q   <= cfg_q;
      end
    end
  end

  assign out_valid = rd_q;
  assign out_env   = rd_q ? env_data : env_hold_q;
  assign out_phase = out_phase_q;
  assign out_freq  = out_freq_q;
  assign out_amp   = out_amp_q;
  assign out_cfg   = out_cfg_q;

endmodule

// File: tb/tb_pulse_env_player.sv
// Directed bench for pulse_env_player with an envelope memory model and a
// sample scoreboard keyed on read order.
module tb_pulse_env_player;

  logic        clk;
  logic        reset;
  logic        cstrobe;
  logic [23:0] env_word;
  logic [16:0] phase;
  logic [8:0]  freq;
  logic [15:0] amp;
  logic [3:0]  cfg;
  logic        env_rd_en;
  logic [11:0] env_addr;
  logic [31:0] env_data;
  logic        out_valid;
  logic [31:0] out_env;
  logic [16:0] out_phase;
  logic [8:0]  out_freq;
  logic [15:0] out_amp;
  logic [3:0]  out_cfg;
  logic        busy;
  logic        pulse_done;
  logic        preempt;

  pulse_env_player dut (
    .clk        (clk),
    .reset      (reset),
    .cstrobe    (cstrobe),
    .env_word   (env_word),
    .phase      (phase),
    .freq       (freq),
    .amp        (amp),
    .cfg        (cfg),
    .env_rd_en  (env_rd_en),
    .env_addr   (env_addr),
    .env_data   (env_data),
    .out_valid  (out_valid),
    .out_env    (out_env),
    .out_phase  (out_phase),
    .out_freq   (out_freq),
    .out_amp    (out_amp),
    .out_cfg    (out_cfg),
    .busy       (busy),
    .pulse_done (pulse_done),
    .preempt    (preempt)
  );

  // clock / reset / cycle index
  int cyc = 0;
  initial clk = 1'b0;
  always #5 clk = ~clk;
  always @(posedge clk) cyc <= cyc + 1;

  // envelope memory: data valid one cycle after the read, junk otherwise
  logic [31:0] mem [0:4095];
  always @(posedge clk) env_data <= env_rd_en ? mem[env_addr] : 32'($urandom);

  // scoreboard
  logic [77:0] exp_q[$];
  int          n_checks = 0;
  int          n_fail   = 0;
  int          n_valid, n_rd, n_busy, first_v, last_v;
  int          done_c[$];
  int          pre_c[$];

  task automatic check(input string tag, input logic [127:0] obs, input logic [127:0] exp);
    n_checks++;
    assert (obs === exp) else begin
      n_fail++;
      $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
    end
  endtask

  always @(negedge clk) begin
    if (!reset) begin
      if (out_valid) begin
        n_valid++;
        if (n_valid == 1) first_v = cyc;
        last_v = cyc;
        if (exp_q.size() == 0) check("unexpected_sample", exp_q.size(), 1);
        else check("sample", {out_env, out_phase, out_freq, out_amp, out_cfg}, exp_q.pop_front());
      end
      if (env_rd_en) n_rd++;
      if (busy) n_busy++;
      if (pulse_done) done_c.push_back(cyc);
      if (preempt) pre_c.push_back(cyc);
    end
  end

  // driver tasks
  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic wait_cycle(input int target);
    while (cyc < target) tick();
  endtask

  task automatic clear_mon();
    n_valid = 0; n_rd = 0; n_busy = 0; first_v = -1; last_v = -1;
    done_c.delete();
    pre_c.delete();
  endtask

  task automatic push_pulse(input logic [11:0] start, input int n, input logic [16:0] ph,
                            input logic [8:0] fq, input logic [15:0] am, input logic [3:0] cf);
    logic [11:0] a;
    for (int i = 0; i < n; i++) begin
      a = start + 12'(i);
      exp_q.push_back({mem[a], ph, fq, am, cf});
    end
  endtask

  task automatic start_pulse(input logic [11:0] start, input logic [11:0] len, input logic [16:0] ph,
                             input logic [8:0] fq, input logic [15:0] am, input logic [3:0] cf,
                             output int c);
    env_word = {len, start};
    phase = ph; freq = fq; amp = am; cfg = cf;
    cstrobe = 1'b1;
    c = cyc;
    tick();
    cstrobe  = 1'b0;
    env_word = 24'($urandom);
    phase = 17'($urandom); freq = 9'($urandom); amp = 16'($urandom); cfg = 4'($urandom);
  endtask

  task automatic wait_idle(input string tag);
    int k;
    k = 0;
    while ((busy || exp_q.size() != 0) && k < 60) begin
      tick();
      k++;
    end
    check({tag, "_drain"}, (k < 60), 1'b1);
    repeat (3) tick();
  endtask

  function automatic int q_first(input int q[$]);
    return (q.size() > 0) ? q[0] : -1;
  endfunction

  int          c, cb;
  logic [11:0] rlen, rstart;
  logic [16:0] rph;
  logic [8:0]  rfq;
  logic [15:0] ram;
  logic [3:0]  rcf;

  initial begin
    for (int i = 0; i < 4096; i++) mem[i] = {12'(i), 20'($urandom)};
    cstrobe = 1'b0; env_word = '0; phase = '0; freq = '0; amp = '0; cfg = '0;
    reset = 1'b1;
    clear_mon();
    #1;
    check("reset_outputs", {env_rd_en, env_addr, out_valid, out_env, out_phase, out_freq,
                            out_amp, out_cfg, busy, pulse_done, preempt}, '0);
    repeat (3) tick();
    reset = 1'b0;
    repeat (2) tick();

    // basic pulse
    clear_mon();
    push_pulse(12'h100, 4, 17'h1ABCD, 9'h055, 16'h7FFF, 4'h3);
    start_pulse(12'h100, 12'd4, 17'h1ABCD, 9'h055, 16'h7FFF, 4'h3, c);
    wait_idle("basic");
    check("basic_first_valid", first_v, c + 2);
    check("basic_last_valid", last_v, c + 5);
    check("basic_done_cnt", done_c.size(), 1);
    check("basic_done_cyc", q_first(done_c), c + 5);
    check("basic_reads", n_rd, 4);
    check("basic_busy_cycles", n_busy, 4);
    check("basic_no_preempt", pre_c.size(), 0);
    check("basic_hold_env", out_env, mem[12'h103]);
    check("basic_hold_phase", out_phase, 17'h1ABCD);

    // address wrap
    clear_mon();
    push_pulse(12'hFFE, 4, 17'h00011, 9'h1FF, 16'h1234, 4'hA);
    start_pulse(12'hFFE, 12'd4, 17'h00011, 9'h1FF, 16'h1234, 4'hA, c);
    wait_idle("wrap");
    check("wrap_done_cyc", q_first(done_c), c + 5);
    check("wrap_valid_cnt", n_valid, 4);

    // back-to-back: B strobed on A's final read
    clear_mon();
    push_pulse(12'h200, 3, 17'h0AAAA, 9'h011, 16'h1111, 4'h1);
    push_pulse(12'h300, 5, 17'h15555, 9'h022, 16'h2222, 4'h2);
    start_pulse(12'h200, 12'd3, 17'h0AAAA, 9'h011, 16'h1111, 4'h1, c);
    wait_cycle(c + 3);
    start_pulse(12'h300, 12'd5, 17'h15555, 9'h022, 16'h2222, 4'h2, cb);
    wait_idle("b2b");
    check("b2b_first_valid", first_v, c + 2);
    check("b2b_last_valid", last_v, c + 9);
    check("b2b_valid_cnt", n_valid, 8);
    check("b2b_done_cnt", done_c.size(), 2);
    check("b2b_done_a", q_first(done_c), c + 4);
    check("b2b_done_b", (done_c.size() > 1) ? done_c[1] : -1, c + 9);
    check("b2b_no_preempt", pre_c.size(), 0);

    // preempt: B strobed mid-pulse
    clear_mon();
    push_pulse(12'h400, 4, 17'h00F0F, 9'h100, 16'h4444, 4'h4);
    push_pulse(12'h500, 2, 17'h1F0F0, 9'h0FF, 16'h5555, 4'h5);
    start_pulse(12'h400, 12'd10, 17'h00F0F, 9'h100, 16'h4444, 4'h4, c);
    wait_cycle(c + 4);
    start_pulse(12'h500, 12'd2, 17'h1F0F0, 9'h0FF, 16'h5555, 4'h5, cb);
    wait_idle("pre");
    check("pre_cnt", pre_c.size(), 1);
    check("pre_cyc", q_first(pre_c), c + 5);
    check("pre_done_cnt", done_c.size(), 1);
    check("pre_done_cyc", q_first(done_c), c + 7);
    check("pre_last_valid", last_v, c + 7);
    check("pre_valid_cnt", n_valid, 6);

    // zero length from IDLE
    clear_mon();
    start_pulse(12'h600, 12'd0, 17'h00001, 9'h001, 16'h0001, 4'h1, c);
    wait_idle("zero");
    check("zero_done_cyc", q_first(done_c), c + 1);
    check("zero_done_cnt", done_c.size(), 1);
    check("zero_no_valid", n_valid, 0);
    check("zero_no_reads", n_rd, 0);
    check("zero_no_busy", n_busy, 0);

    // zero length aborting a running pulse
    clear_mon();
    push_pulse(12'h700, 2, 17'h0CAFE, 9'h0AB, 16'h6666, 4'h6);
    start_pulse(12'h700, 12'd6, 17'h0CAFE, 9'h0AB, 16'h6666, 4'h6, c);
    wait_cycle(c + 2);
    start_pulse(12'h800, 12'd0, 17'h00002, 9'h002, 16'h0002, 4'h2, cb);
    wait_idle("zabort");
    check("zabort_pre_cyc", q_first(pre_c), c + 3);
    check("zabort_done_cyc", q_first(done_c), c + 3);
    check("zabort_done_cnt", done_c.size(), 1);
    check("zabort_reads", n_rd, 2);
    check("zabort_busy", busy, 1'b0);

    // randomized isolated pulses
    for (int r = 0; r < 4; r++) begin
      rlen = 12'($urandom_range(1, 7));
      rstart = 12'($urandom_range(0, 4095));
      rph = 17'($urandom); rfq = 9'($urandom); ram = 16'($urandom); rcf = 4'($urandom);
      clear_mon();
      push_pulse(rstart, int'(rlen), rph, rfq, ram, rcf);
      start_pulse(rstart, rlen, rph, rfq, ram, rcf, c);
      wait_idle("rand");
      check("rand_done_cyc", q_first(done_c), c + 1 + int'(rlen));
      check("rand_valid_cnt", n_valid, int'(rlen));
    end

    // reset in the middle of a pulse
    clear_mon();
    push_pulse(12'h010, 1, 17'h01234, 9'h033, 16'h3333, 4'h7);
    start_pulse(12'h010, 12'd8, 17'h01234, 9'h033, 16'h3333, 4'h7, c);
    wait_cycle(c + 3);
    check("rst_mid_reading", {env_rd_en, env_addr}, {1'b1, 12'h012});
    reset = 1'b1;
    #1;
    check("rst_mid_outputs", {env_rd_en, env_addr, out_valid, out_env, out_phase, out_freq,
                              out_amp, out_cfg, busy, pulse_done, preempt}, '0);
    repeat (2) tick();
    reset = 1'b0;
    clear_mon();
    repeat (6) tick();
    check("rst_after_reads", n_rd, 0);
    check("rst_after_done", done_c.size(), 0);
    check("rst_after_busy", busy, 1'b0);
    check("scoreboard_empty", exp_q.size(), 0);

    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule
